// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex table,
// the all-off pattern, the dp bit position and a width helper.
package seg7_pkg;

  localparam int unsigned DP_BIT      = 7;
  localparam logic [7:0]  SEG_ALL_OFF = 8'hFF;

  // Active-low patterns for 0..F, dp off; bit6..0 = g..a
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Bits needed to hold 0..v-1; never less than 1 so single-digit builds still get a register.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + dp to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern         = HEX_SEG[nibble];
    pattern[DP_BIT] = ~dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with prescaled scan, dead time,
// leading-zero suppression and a frame-synchronous double-buffered load.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter bit          AN_ACTIVE_LOW  = 1,
  parameter bit          SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = clog2(SCAN_DIV);
  localparam int unsigned DIG_W = clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? SEG_ALL_OFF : ~SEG_ALL_OFF;

  logic [CNT_W-1:0]      cnt;
  logic [DIG_W-1:0]      dig;
  logic                  slot_end, frame_end, dead;

  logic [4*NUM_DIGITS-1:0] pend_value, sh_value;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, sh_dp, sh_blank;

  logic [3:0]            nib_sel;
  logic                  dp_sel, blank_sel, supp_sel;
  logic [7:0]            dec_pat, pat;
  logic [NUM_DIGITS-1:0] an_on;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (dig == DIG_LAST);
  assign dead      = (cnt < CNT_DEAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dig         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow takes the pending contents held before this edge, so a load coinciding
  // with the boundary lands in pending and waits a further frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blank   <= '1;
    end else begin
      if (frame_end && pending) begin
        sh_value <= pend_value;
        sh_dp    <= pend_dp;
        sh_blank <= pend_blank;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // A digit is lzs-suppressed when it and every digit to its left hold zero.
  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    supp_sel  = 1'b0;
    an_on     = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (DIG_W'(k) == dig) begin
        nib_sel   = sh_value[4*k +: 4];
        dp_sel    = sh_dp[k];
        blank_sel = sh_blank[k];
        supp_sel  = lzs_en && (k != 0);
        for (int unsigned j = k; j < NUM_DIGITS; j++) begin
          if (sh_value[4*j +: 4] != 4'h0) supp_sel = 1'b0;
        end
        an_on[k] = !dead && !sh_blank[k];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble  (nib_sel),
    .dp      (dp_sel),
    .pattern (dec_pat)
  );

  always_comb begin
    pat = dec_pat;
    if (dead || blank_sel) begin
      pat = SEG_ALL_OFF;
    end else if (supp_sel) begin
      pat         = SEG_ALL_OFF;
      pat[DP_BIT] = ~dp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= AN_ACTIVE_LOW ? ~an_on : an_on;
      seg <= SEG_ACTIVE_LOW ? pat : ~pat;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-clock slots, 2 dead clocks, active-low.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst, load, lzs_en;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        pending, frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .lzs_en(lzs_en), .seg(seg), .an(an), .pending(pending), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // t = cycles since the frame_start cycle; outputs lag the scan by one clock.
  task automatic check_cycle(input int t, input logic [31:0] segs, input logic [3:0] blank);
    int d, ph;
    logic [3:0] ea;
    logic [7:0] es;
    d  = (t - 1) / 8;
    ph = (t - 1) % 8;
    if (ph < 2 || blank[d]) begin
      ea = 4'hF;
      es = 8'hFF;
    end else begin
      ea = ~(4'b0001 << d);
      es = segs[d*8 +: 8];
    end
    chk("an", an, ea);
    chk("seg", seg, es);
  endtask

  task automatic run_frame(input logic [31:0] segs, input logic [3:0] blank,
                           input logic pend_mid, input logic pend_end);
    for (int t = 1; t <= 32; t++) begin
      @(negedge clk);
      load = 1'b0;
      check_cycle(t, segs, blank);
      chk("pending", pending, (t == 32) ? pend_end : pend_mid);
      chk("frame_start", frame_start, t == 32);
    end
  endtask

  // Bench-side scan counter; tprev is the cnt that produced the currently visible outputs.
  int tcnt, tprev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= 0;
      tprev <= 0;
    end else begin
      tprev <= tcnt;
      tcnt  <= (tcnt == 7) ? 0 : tcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", 32'($onehot0(~an)), 32'd1);
      if (tprev < 2) chk("dead_an", an, 4'hF);
    end
  end

  logic [31:0] prev_segs;
  logic [3:0]  prev_blank;

  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}};
    vecs[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h99, 8'hC0}};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[4] = '{16'h0005, 4'b1110, 4'b0100, 1'b1, {8'h7F, 8'hFF, 8'h7F, 8'h92}};
    vecs[5] = '{16'h8E3D, 4'b1111, 4'b0000, 1'b1, {8'h00, 8'h06, 8'h30, 8'h21}};

    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lzs_en = 1'b0;
    @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_pending", pending, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Three dark frames with frame_start every 32 clocks
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      chk("idle_an", an, 4'hF);
      chk("idle_seg", seg, 8'hFF);
      chk("idle_pending", pending, 1'b0);
      chk("idle_frame_start", frame_start, (i % 32) == 0);
    end

    // Table: old frame persists while pending, new one follows the boundary
    prev_segs  = 32'hFFFF_FFFF;
    prev_blank = 4'hF;
    for (int i = 0; i < 6; i++) begin
      value = vecs[i].value; dp_in = vecs[i].dp; blank_in = vecs[i].blank;
      load  = 1'b1;
      run_frame(prev_segs, prev_blank, 1'b1, 1'b0);
      lzs_en = vecs[i].lzs;
      run_frame(vecs[i].segs, vecs[i].blank, 1'b0, 1'b0);
      prev_segs  = vecs[i].segs;
      prev_blank = vecs[i].blank;
    end

    // Mid-frame load, then a second load in the boundary cycle
    value = 16'h1111; dp_in = '0; blank_in = '0; lzs_en = 1'b0;
    load  = 1'b1;
    for (int t = 1; t <= 31; t++) begin
      @(negedge clk);
      load = 1'b0;
      check_cycle(t, prev_segs, prev_blank);
      chk("tear_pending", pending, 1'b1);
    end
    value = 16'h2222;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_cycle(32, prev_segs, prev_blank);
    chk("bnd_pending", pending, 1'b1);
    chk("bnd_frame_start", frame_start, 1'b1);
    run_frame({4{8'hF9}}, 4'h0, 1'b1, 1'b0);
    run_frame({4{8'hA4}}, 4'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-slot with a load pending
    value = 16'h3333;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pre_rst_pending", pending, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_an", an, 4'b1110);
    chk("pre_rst_seg", seg, 8'hA4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_pending", pending, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("post_rst_an", an, 4'hF);
      chk("post_rst_seg", seg, 8'hFF);
      chk("post_rst_pending", pending, 1'b0);
    end

    // Random loads exercise the one-hot and dead-time monitors
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      load     = ($urandom_range(0, 3) == 0);
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom);
      lzs_en   = 1'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display. Successor to the single-digit hex-to-segment decoder.
- Adds:
  - parametrised digit count;
  - a scan prescaler;
  - per-digit decimal point and blank controls;
  - leading-zero suppression;
  - anti-ghosting dead time;
  - a double-buffered load so an update never tears mid-frame.
- Sits between the datapath (registers or counters to show) and the board pins.

Parameters:
- NUM_DIGITS, 4, digits driven (1..8).
- SCAN_DIV, 50000, clocks per digit slot (>= DEAD_CYCLES+2).
- DEAD_CYCLES, 16, clocks at the start of each slot with all anodes off (0 allowed).
- AN_ACTIVE_LOW, 1, 1 means the anode enable is driven low.
- SEG_ACTIVE_LOW, 1, 1 means a lit segment is driven low (polarity used by the existing decode table).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe; captures value/dp_in/blank_in
- value  in  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit
- dp_in  in  NUM_DIGITS  decimal-point enable per digit
- blank_in  in  NUM_DIGITS  force digit dark
- lzs_en  in  1  leading-zero suppression enable (live, not buffered)
- seg  out  8  bit7 = dp, bits6:0 = g..a, polarity per SEG_ACTIVE_LOW
- an  out  NUM_DIGITS  digit enables, one-hot active, polarity per AN_ACTIVE_LOW
- pending  out  1  loaded data waiting for the frame boundary
- frame_start  out  1  one-cycle pulse when scan returns to digit 0

Behaviour:
- Reset (asynchronous, active-high):
  - cnt = 0, dig = 0, pending = 0, frame_start = 0;
  - shadow value = 0, shadow dp = 0, shadow blank = all ones (display dark until first load);
  - an = all inactive, seg = all segments off (0xFF when active-low).
  - Reset mid-scan or mid-load aborts everything to this state; the pending buffer is discarded.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1.
  - At terminal count, cnt -> 0 and dig -> dig+1, wrapping from NUM_DIGITS-1 to 0.
- frame_start is registered. It is high for exactly the cycle in which dig holds 0 after a wrap. It does not pulse after reset.
- Load buffering:
  - load = 1 copies the inputs into the pending registers and sets pending. Multiple loads before a boundary: last wins.
  - At the frame boundary (terminal count with dig = NUM_DIGITS-1), if pending: pending regs -> shadow, pending clears.
  - load in the same cycle as the boundary:
    - the shadow receives the pending contents held before that cycle;
    - the new data lands in pending;
    - pending stays 1.
- Digit content for digit k (from shadow):
  - Lit pattern = hex decode of nibble k, with dp_k ORed into bit7.
  - Dark if blank_k = 1.
  - Dark if lzs_en = 1, k != 0, and nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. A digit's dp still lights when its digit is suppressed by lzs, but not when it is blanked.
- Dead time: while cnt < DEAD_CYCLES, all anodes are inactive and seg is all-off.
- Output timing:
  - an and seg are registered, so each reflects cnt/dig/shadow of the previous cycle (1-cycle latency).
  - Only the anode of dig is ever active; no two anodes are ever active in the same cycle.
- Hex decode table (active-low, dp off), values 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. Invert when SEG_ACTIVE_LOW = 0.
- NUM_DIGITS = 1: dig is constant 0, and every terminal count is a frame boundary.

Decomposition:
- Package seg7_pkg:
  - the 16-entry hex segment constant table;
  - SEG_ALL_OFF;
  - the bit-position constant for dp;
  - the function clog2 used for the cnt/dig widths.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble plus dp -> 8-bit active-low pattern. The top level applies the polarity.

Test Plan:
- All scenarios use NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, both polarities active-low.
- Reset release: no load -> an = 4'b1111 and seg = 8'hFF for 3 full frames (96 clocks); pending = 0; first frame_start at clock 32.
- Load value=16'h12AF, dp_in=4'b0100, blank_in=0, lzs_en=0 -> after the next boundary, per 8-clock slot: 2 dark clocks, then an=1110 seg=8E; an=1101 seg=88; an=1011 seg=24 (2 with dp); an=0111 seg=F9.
- Tear-free update:
  - Load 16'h1111 mid-frame: pending = 1, and the old frame continues unchanged to its end.
  - The new pattern starts at the slot immediately after the boundary, and pending clears then.
  - A second load in the boundary cycle leaves pending = 1 for the following frame.
- Leading-zero suppression: value 16'h0040, lzs_en=1 -> digits 3 and 2 dark, digit 1 = 99, digit 0 = C0. value 16'h0000 -> only digit 0 lit (C0). Toggle lzs_en=0 -> all four show C0.
- Reset asserted asynchronously mid-slot with pending = 1 -> an and seg go inactive in the same cycle without waiting for a clock edge; after release, the display stays dark (pending discarded).
- Dead time and one-hot checks: over 1000 random-load cycles, assert $onehot0(~an) every cycle, and assert an all-inactive whenever the cnt driving the output was < 2.
